// File: rtl/div_unit.sv
// div_unit: iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the E stage.
// One quotient bit per cycle; the full operation takes XLEN+2 cycles from accept to valid.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip the
// iteration and report valid one cycle after accept.
//
// Handshake: start_i is a level held by the stalled E stage. An accept happens only
// in IDLE when start_i=1 and kill_i=0; operands are sampled on that cycle only.
// valid_o is a one-cycle pulse in DONE, and the start_i level still present in DONE
// is not a new accept. kill_i aborts in any state and suppresses the pulse.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] srca_i,
    input  logic [XLEN-1:0] srcb_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int CW = $clog2(XLEN + 1);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        op_q, op_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
`ifndef DIV_FASTPATH_EN
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
`endif

    // Operand decode on the accept cycle.
    logic              accept;
    logic              is_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              b_zero, ovf, special;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN:0]     shifted, diff;
    logic [XLEN-1:0]   fin_val;

    assign accept    = (state_q == S_IDLE) && start_i && !kill_i;
    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & srca_i[XLEN-1];
    assign b_neg     = is_signed & srcb_i[XLEN-1];
    assign a_abs     = a_neg ? -srca_i : srca_i;
    assign b_abs     = b_neg ? -srcb_i : srcb_i;
    assign b_zero    = (srcb_i == '0);
    assign ovf       = is_signed && (srca_i == {1'b1, {(XLEN-1){1'b0}}}) && (srcb_i == '1);
    assign special   = b_zero | ovf;

    // Restoring step: shift the next dividend bit into the partial remainder.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, div_q};

    // Forced RISC-V results for divide-by-zero and signed overflow.
    always_comb begin
        spec_val = '0;
        if (b_zero) begin
            spec_val = op_i[1] ? srca_i : '1;
        end else begin
            spec_val = op_i[1] ? '0 : srca_i;
        end
    end

    // Sign correction of the unsigned iteration result.
    always_comb begin
        fin_val = '0;
        if (op_q[1]) begin
            fin_val = a_neg_q ? -rem_q : rem_q;
        end else begin
            fin_val = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef DIV_FASTPATH_EN
                    state_d = special ? S_DONE : S_BUSY;
`else
                    state_d = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else if (count_q == CW'(1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: state_d = kill_i ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; a kill in DONE withdraws the pulse.
    always_comb begin
        valid_o  = (state_q == S_DONE) && !kill_i;
        busy_o   = (state_q != S_IDLE);
        state_o  = state_q;
        result_o = result_q;
    end

    // Datapath next-state: load on accept, iterate in BUSY, finalise in SIGN.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        count_d  = count_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        result_d = result_q;
`ifndef DIV_FASTPATH_EN
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
`endif
        if (accept) begin
            op_d    = op_i;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            quo_d   = a_abs;
            div_d   = b_abs;
            rem_d   = '0;
            count_d = CW'(XLEN);
`ifdef DIV_FASTPATH_EN
            if (special) begin
                result_d = spec_val;
            end
`else
            spec_d     = special;
            spec_res_d = spec_val;
`endif
        end else if (state_q == S_BUSY && !kill_i) begin
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            count_d = count_q - CW'(1);
        end else if (state_q == S_SIGN && !kill_i) begin
`ifdef DIV_FASTPATH_EN
            result_d = fin_val;
`else
            result_d = spec_q ? spec_res_q : fin_val;
`endif
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            count_q  <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= '0;
`ifndef DIV_FASTPATH_EN
            spec_q     <= 1'b0;
            spec_res_q <= '0;
`endif
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            count_q  <= count_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            result_q <= result_d;
`ifndef DIV_FASTPATH_EN
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
`endif
        end
    end

endmodule
